// File: rtl/awg_cmd_decoder_if.sv
// rtl/awg_cmd_decoder_if.sv - received-byte stream (and optional response channel, AWG_CMD_ACK_EN) into the decoder
interface awg_cmd_decoder_if;
  logic [7:0] uart_data;
  logic       data_valid;
`ifdef AWG_CMD_ACK_EN
  logic [7:0] ack_data;
  logic       ack_valid;
  logic       ack_ready;

  modport master (output uart_data, data_valid, ack_ready, input ack_data, ack_valid);
  modport slave  (input uart_data, data_valid, ack_ready, output ack_data, ack_valid);
`else
  modport master (output uart_data, data_valid);
  modport slave  (input uart_data, data_valid);
`endif
endinterface

// File: rtl/awg_cmd_decoder.sv
// rtl/awg_cmd_decoder.sv - frames UART bytes into checksummed AWG register writes
// Optional ACK/NAK response channel enabled by macro AWG_CMD_ACK_EN.
module awg_cmd_decoder #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [1:0]  DEF_WAVE       = 2'd0,
  parameter logic [15:0] DEF_FREQ       = 16'd1000,
  parameter logic [9:0]  DEF_AMP        = 10'd512,
  parameter logic [9:0]  DEF_OFFS       = 10'd512
) (
  input  logic               clk,
  input  logic               rst_n,
  awg_cmd_decoder_if.slave   bus,
  output logic [1:0]         waveform_type,
  output logic [15:0]        frequency,
  output logic [9:0]         amplitude,
  output logic [9:0]         dc_offset,
  output logic               cfg_update,
  output logic               err_checksum,
  output logic               err_cmd,
  output logic               err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {IDLE, GOT_SYNC, GOT_CMD, GOT_DH, GOT_DL} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [7:0]     cmd_q, dh_q, dl_q, cmd_n, dh_n, dl_n;
  logic [1:0]     wave_n;
  logic [15:0]    freq_n;
  logic [9:0]     amp_n, offs_n;
  logic           upd_n, ecs_n, ecmd_n, eto_n;
  logic           resp_set;
  logic [7:0]     resp_code;
  logic [15:0]    data_w;
  logic [9:0]     data_sat;

  assign data_w   = {dh_q, dl_q};
  assign data_sat = (|data_w[15:10]) ? 10'h3FF : data_w[9:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cmd_q         <= '0;
      dh_q          <= '0;
      dl_q          <= '0;
      waveform_type <= DEF_WAVE;
      frequency     <= DEF_FREQ;
      amplitude     <= DEF_AMP;
      dc_offset     <= DEF_OFFS;
      cfg_update    <= 1'b0;
      err_checksum  <= 1'b0;
      err_cmd       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      cmd_q         <= cmd_n;
      dh_q          <= dh_n;
      dl_q          <= dl_n;
      waveform_type <= wave_n;
      frequency     <= freq_n;
      amplitude     <= amp_n;
      dc_offset     <= offs_n;
      cfg_update    <= upd_n;
      err_checksum  <= ecs_n;
      err_cmd       <= ecmd_n;
      err_timeout   <= eto_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cmd_n     = cmd_q;
    dh_n      = dh_q;
    dl_n      = dl_q;
    wave_n    = waveform_type;
    freq_n    = frequency;
    amp_n     = amplitude;
    offs_n    = dc_offset;
    upd_n     = 1'b0;
    ecs_n     = 1'b0;
    ecmd_n    = 1'b0;
    eto_n     = 1'b0;
    resp_set  = 1'b0;
    resp_code = ACK;

    if (state == IDLE) begin
      cnt_n = '0;
      if (bus.data_valid && bus.uart_data == SYNC)
        state_n = GOT_SYNC;
    end else if (bus.data_valid) begin
      // An arriving byte always beats a coincident timeout expiry.
      cnt_n = '0;
      case (state)
        GOT_SYNC: begin cmd_n = bus.uart_data; state_n = GOT_CMD; end
        GOT_CMD:  begin dh_n  = bus.uart_data; state_n = GOT_DH;  end
        GOT_DH:   begin dl_n  = bus.uart_data; state_n = GOT_DL;  end
        default: begin
          state_n  = IDLE;
          resp_set = 1'b1;
          if (bus.uart_data != (cmd_q ^ dh_q ^ dl_q)) begin
            ecs_n     = 1'b1;
            resp_code = NAK;
          end else begin
            case (cmd_q)
              8'h00: begin
                wave_n = DEF_WAVE;
                freq_n = DEF_FREQ;
                amp_n  = DEF_AMP;
                offs_n = DEF_OFFS;
                upd_n  = 1'b1;
              end
              8'h01: begin wave_n = dl_q[1:0]; upd_n = 1'b1; end
              8'h02: begin freq_n = data_w;    upd_n = 1'b1; end
              8'h03: begin amp_n  = data_sat;  upd_n = 1'b1; end
              8'h04: begin offs_n = data_sat;  upd_n = 1'b1; end
              default: begin ecmd_n = 1'b1; resp_code = NAK; end
            endcase
          end
        end
      endcase
    end else if (cnt == CNT_MAX) begin
      state_n   = IDLE;
      cnt_n     = '0;
      eto_n     = 1'b1;
      resp_set  = 1'b1;
      resp_code = NAK;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end

`ifdef AWG_CMD_ACK_EN
  logic [7:0] ack_data_q;
  logic       ack_valid_q;

  // Single-entry response buffer; a newer response replaces a pending one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_data_q  <= 8'h00;
      ack_valid_q <= 1'b0;
    end else if (resp_set) begin
      ack_data_q  <= resp_code;
      ack_valid_q <= 1'b1;
    end else if (ack_valid_q && bus.ack_ready) begin
      ack_valid_q <= 1'b0;
    end
  end

  assign bus.ack_data  = ack_data_q;
  assign bus.ack_valid = ack_valid_q;
`else
  logic unused_resp;
  assign unused_resp = resp_set ^ (^resp_code);
`endif

endmodule

// File: tb/tb_awg_cmd_decoder.sv
// tb/tb_awg_cmd_decoder.sv - directed frames checked against a frame-level model every cycle
module tb_awg_cmd_decoder;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  awg_cmd_decoder_if bus ();

  logic [1:0]  waveform_type;
  logic [15:0] frequency;
  logic [9:0]  amplitude, dc_offset;
  logic        cfg_update, err_checksum, err_cmd, err_timeout;

  awg_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .waveform_type(waveform_type), .frequency(frequency),
    .amplitude(amplitude), .dc_offset(dc_offset),
    .cfg_update(cfg_update), .err_checksum(err_checksum),
    .err_cmd(err_cmd), .err_timeout(err_timeout)
  );

`ifdef AWG_CMD_ACK_EN
  assign bus.ack_ready = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect bytes, count idle gap, interpret a full frame.
  int m_wave, m_freq, m_amp, m_offs;
  bit m_upd, m_ecs, m_ecmd, m_eto;
  bit in_frame;
  int gap;
  logic [7:0] fr[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wave = 0; m_freq = 1000; m_amp = 512; m_offs = 512;
      m_upd = 0; m_ecs = 0; m_ecmd = 0; m_eto = 0;
      in_frame = 0; gap = 0; fr.delete();
    end else begin
      m_upd = 0; m_ecs = 0; m_ecmd = 0; m_eto = 0;
      if (in_frame) begin
        if (bus.data_valid) begin
          fr.push_back(bus.uart_data);
          gap = 0;
          if (fr.size() == 5) begin
            int d;
            in_frame = 0;
            d = fr[2] * 256 + fr[3];
            if (fr[4] != (fr[1] ^ fr[2] ^ fr[3])) m_ecs = 1;
            else begin
              case (fr[1])
                0: begin m_wave = 0; m_freq = 1000; m_amp = 512; m_offs = 512; m_upd = 1; end
                1: begin m_wave = d % 4; m_upd = 1; end
                2: begin m_freq = d; m_upd = 1; end
                3: begin m_amp = (d > 1023) ? 1023 : d; m_upd = 1; end
                4: begin m_offs = (d > 1023) ? 1023 : d; m_upd = 1; end
                default: m_ecmd = 1;
              endcase
            end
          end
        end else begin
          gap++;
          if (gap == T) begin in_frame = 0; m_eto = 1; end
        end
      end else if (bus.data_valid && bus.uart_data == 8'hA5) begin
        in_frame = 1; gap = 0; fr.delete(); fr.push_back(8'hA5);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("waveform_type", 32'(waveform_type), 32'(m_wave));
      check("frequency", 32'(frequency), 32'(m_freq));
      check("amplitude", 32'(amplitude), 32'(m_amp));
      check("dc_offset", 32'(dc_offset), 32'(m_offs));
      check("cfg_update", 32'(cfg_update), 32'(m_upd));
      check("err_checksum", 32'(err_checksum), 32'(m_ecs));
      check("err_cmd", 32'(err_cmd), 32'(m_ecmd));
      check("err_timeout", 32'(err_timeout), 32'(m_eto));
    end
  end

  task automatic put(input logic [7:0] b);
    @(posedge clk); #1;
    bus.data_valid = 1'b1;
    bus.uart_data  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.data_valid = 1'b0;
      bus.uart_data  = 8'h00;
    end
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
    put(8'hA5); put(c); put(h); put(l); put(k);
    idle(1);
  endtask

  initial begin
    bus.data_valid = 1'b0;
    bus.uart_data  = 8'h00;
    #23;
    check("rst_wave", 32'(waveform_type), 32'd0);
    check("rst_freq", 32'(frequency), 32'd1000);
    check("rst_amp", 32'(amplitude), 32'd512);
    check("rst_offs", 32'(dc_offset), 32'd512);
    check("rst_pulses", {28'd0, cfg_update, err_checksum, err_cmd, err_timeout}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    frame(8'h02, 8'h12, 8'h34, 8'h24);
    check("lit_freq_1234", 32'(frequency), 32'h1234);
    check("lit_upd_freq", 32'(cfg_update), 32'd1);
    check("lit_amp_keep", 32'(amplitude), 32'd512);
    idle(1);
    check("lit_upd_one_cycle", 32'(cfg_update), 32'd0);

    frame(8'h03, 8'h05, 8'h00, 8'h06);
    check("lit_amp_sat", 32'(amplitude), 32'd1023);

    frame(8'h01, 8'h00, 8'h02, 8'h00);
    check("lit_err_chk", 32'(err_checksum), 32'd1);
    check("lit_wave_keep", 32'(waveform_type), 32'd0);
    frame(8'h01, 8'h00, 8'h02, 8'h03);
    check("lit_wave_2", 32'(waveform_type), 32'd2);

    frame(8'h07, 8'h00, 8'h00, 8'h07);
    check("lit_err_cmd", 32'(err_cmd), 32'd1);
    put(8'h11); put(8'h22); idle(2);

    frame(8'h04, 8'h00, 8'hC8, 8'hCC);
    check("lit_offs_200", 32'(dc_offset), 32'd200);

    // 16 idle cycles after a partial frame abandon it.
    put(8'hA5); put(8'h02); idle(17);
    check("lit_timeout", 32'(err_timeout), 32'd1);
    frame(8'h02, 8'h00, 8'h10, 8'h12);
    check("lit_freq_after_to", 32'(frequency), 32'h0010);

    // Byte landing on the expiry cycle keeps the frame alive.
    put(8'hA5); put(8'h02); idle(15);
    put(8'h00); put(8'h20); put(8'h22); idle(1);
    check("lit_freq_expiry_byte", 32'(frequency), 32'h0020);

    frame(8'h02, 8'hA5, 8'h01, 8'hA6);
    check("lit_freq_midsync", 32'(frequency), 32'hA501);

    frame(8'h00, 8'hFF, 8'hFF, 8'h00);
    check("lit_cmd0_freq", 32'(frequency), 32'd1000);
    check("lit_cmd0_offs", 32'(dc_offset), 32'd512);

    frame(8'h02, 8'h00, 8'h07, 8'h05);
    put(8'hA5); put(8'h02); put(8'h12); idle(1);
    rst_n = 1'b0;
    #3;
    check("lit_async_rst_freq", 32'(frequency), 32'd1000);
    idle(1);
    rst_n = 1'b1;
    put(8'h34); put(8'h24); idle(3);
    check("lit_lost_frame", 32'(frequency), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
